// File: rtl/dm_ctrl.sv
// Data memory controller: byte-enabled writes, registered reads with a valid strobe,
// ready handshake, sequential clear engine and error reporting.
module dm_ctrl #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 10,
    parameter  int DEPTH  = 1024,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_read,
    input  logic              DM_write,
    input  logic [ADDR_W-1:0] DM_address,
    input  logic [DATA_W-1:0] DM_in,
    input  logic [BE_W-1:0]   DM_be,
    input  logic              clear_req,
    output logic              DM_ready,
    output logic [DATA_W-1:0] DM_out,
    output logic              DM_valid,
    output logic              DM_err,
    output logic              clear_busy
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                clr_we, wr_acc, rd_acc, in_range;
    logic [IDX_W-1:0]    idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign in_range = ({1'b0, DM_address} < DEPTH_L);
    assign idx      = DM_address[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        wr_acc  = 1'b0;
        rd_acc  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            IDLE: begin
                // A clear request wins over any request in the same cycle; that request is flagged.
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    err_d   = DM_read | DM_write;
                end else if (DM_read || DM_write) begin
                    if ((DM_read && DM_write) || !in_range) begin
                        err_d = 1'b1;
                    end else if (DM_write) begin
                        wr_acc = 1'b1;
                    end else begin
                        rd_acc = 1'b1;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
        valid_d = rd_acc;
        out_d   = rd_acc ? mem[idx] : out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // The array has no reset; the clear engine is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr_q[IDX_W-1:0]] <= '0;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (DM_be[i]) begin
                    mem[idx][8*i +: 8] <= DM_in[8*i +: 8];
                end
            end
        end
    end

    assign DM_ready   = (state_q == IDLE);
    assign clear_busy = (state_q == CLEAR);
    assign DM_out     = out_q;
    assign DM_valid   = valid_q;
    assign DM_err     = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed, table-driven bench for dm_ctrl with DEPTH=16, plus hand-written
// sequences for the clear engine and reset-during-clear.
module tb_dm_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              DM_read, DM_write, clear_req;
    logic [ADDR_W-1:0] DM_address;
    logic [DATA_W-1:0] DM_in;
    logic [BE_W-1:0]   DM_be;
    logic              DM_ready, DM_valid, DM_err, clear_busy;
    logic [DATA_W-1:0] DM_out;

    int n_cmp = 0;
    int n_bad = 0;

    dm_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .DM_read    (DM_read),
        .DM_write   (DM_write),
        .DM_address (DM_address),
        .DM_in      (DM_in),
        .DM_be      (DM_be),
        .clear_req  (clear_req),
        .DM_ready   (DM_ready),
        .DM_out     (DM_out),
        .DM_valid   (DM_valid),
        .DM_err     (DM_err),
        .clear_busy (clear_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [BE_W-1:0]   be;
        logic              exp_valid;
        logic              exp_err;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
        DM_read    = rd;
        DM_write   = wr;
        DM_address = a;
        DM_in      = d;
        DM_be      = be;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, '0, '0, '0);
        clear_req = 1'b0;
    endtask

    // Called on a negedge while clear_busy should be high; returns cycles spent busy.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        logic [ADDR_W-1:0] a;

        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 5'd15, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 5'd5,  32'h1122_3344, 4'b0101, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 5'd5,  32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hDE22_BE44};
        vecs[5]  = '{1'b0, 1'b1, 5'd3,  32'hA5A5_A5A5, 4'b1111, 1'b0, 1'b0, 32'hDE22_BE44};
        vecs[6]  = '{1'b1, 1'b0, 5'd3,  32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'hA5A5_A5A5};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 1'b1, 5'd2,  32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b1, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b1, 1'b0, 5'd20, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, 1'b0, 5'd2,  32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 5'd7,  32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b0, 5'd7,  32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b0, 1'b1, 5'd16, 32'h1234_5678, 4'b1111, 1'b0, 1'b1, 32'h0000_0000};
        vecs[14] = '{1'b1, 1'b0, 5'd15, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 32'h0000_0000};

        rst = 1'b0;
        idle_in();
        #1;
        check("reset_ready", 32'(DM_ready), 32'd0);
        check("reset_busy",  32'(clear_busy), 32'd1);
        check("reset_valid", 32'(DM_valid), 32'd0);
        check("reset_err",   32'(DM_err), 32'd0);
        check("reset_out",   DM_out, 32'h0);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        count_busy(cnt);
        check("init_clear_cycles", 32'(cnt), 32'd16);
        check("init_ready", 32'(DM_ready), 32'd1);

        // Back-to-back reads of the whole cleared array.
        for (int i = 0; i < DEPTH; i++) begin
            a = ADDR_W'(i);
            drive(1'b1, 1'b0, a, '0, '0);
            @(negedge clk);
            check("init_rd_valid", 32'(DM_valid), 32'd1);
            check("init_rd_data", DM_out, 32'h0);
        end
        idle_in();
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].be);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 32'(DM_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_err", i),   32'(DM_err),   32'(vecs[i].exp_err));
            check($sformatf("vec%0d_out", i),   DM_out,        vecs[i].exp_out);
        end
        idle_in();
        @(negedge clk);
        check("err_is_pulse", 32'(DM_err), 32'd0);

        // Fill, then clear on request; a mid-clear read must be silently dropped.
        for (int i = 0; i < 4; i++) begin
            a = ADDR_W'(i);
            drive(1'b0, 1'b1, a, 32'h1111_1111 * (i + 1), 4'b1111);
            @(negedge clk);
        end
        idle_in();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 3) check("clr_ready_low", 32'(DM_ready), 32'd0);
            if (cnt == 5) drive(1'b1, 1'b0, 5'd3, '0, '0);
            if (cnt == 6) begin
                check("clr_rd_no_err",   32'(DM_err), 32'd0);
                check("clr_rd_no_valid", 32'(DM_valid), 32'd0);
                idle_in();
            end
            @(negedge clk);
        end
        check("req_clear_cycles", 32'(cnt), 32'd16);
        drive(1'b1, 1'b0, 5'd3, '0, '0);
        @(negedge clk);
        check("post_clear_valid", 32'(DM_valid), 32'd1);
        check("post_clear_data", DM_out, 32'h0);

        // Reset during a clear, with DM_out holding nonzero data.
        drive(1'b0, 1'b1, 5'd0, 32'h0000_00AA, 4'b1111);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, '0, '0);
        @(negedge clk);
        check("pre_rst_data", DM_out, 32'h0000_00AA);
        idle_in();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_clear_busy", 32'(clear_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_busy",  32'(clear_busy), 32'd1);
        check("rst_mid_ready", 32'(DM_ready), 32'd0);
        check("rst_mid_valid", 32'(DM_valid), 32'd0);
        check("rst_mid_out",   DM_out, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        count_busy(cnt);
        check("rst_clear_cycles", 32'(cnt), 32'd16);
        drive(1'b1, 1'b0, 5'd0, '0, '0);
        @(negedge clk);
        check("rst_clear_valid", 32'(DM_valid), 32'd1);
        check("rst_clear_data", DM_out, 32'h0);
        idle_in();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised data memory controller: successor to the single-cycle data memory.
- Adds per-byte write enables, a registered read path with a valid strobe, and a ready handshake.
- Adds a sequential clear engine that zeroes the array after reset or on request, plus out-of-range and conflict error reporting.
- Sits between the core's MEM stage and the on-chip data array.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 10, word address width
DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W
BE_W, DATA_W/8, byte-enable width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
DM_read  input  1  read request, sampled when DM_ready=1
DM_write  input  1  write request, sampled when DM_ready=1
DM_address  input  ADDR_W  word address
DM_in  input  DATA_W  write data
DM_be  input  BE_W  byte enables for writes; bit i covers byte i
clear_req  input  1  single-cycle pulse requesting a full array clear
DM_ready  output  1  controller accepts requests this cycle
DM_out  output  DATA_W  registered read data
DM_valid  output  1  DM_out holds valid data this cycle
DM_err  output  1  one-cycle pulse on a rejected request
clear_busy  output  1  clear engine active

Behaviour:
- Reset (rst=0, async): state<=CLEAR, clear pointer<=0, DM_out<=0, DM_valid<=0, DM_err<=0. DM_ready=0 and clear_busy=1 while in reset.
- The array itself is not reset; the clear engine zeroes it after reset deasserts.
- FSM has two states, CLEAR and IDLE.
- CLEAR:
  - Writes 0 to word[ptr] each cycle, ptr increments.
  - At ptr=DEPTH-1 that word is written and the FSM moves to IDLE next cycle.
  - Takes exactly DEPTH cycles.
  - DM_ready=0 and clear_busy=1 throughout; requests are ignored, with no error pulse.
- IDLE: DM_ready=1, clear_busy=0.
- clear_req in IDLE: FSM moves to CLEAR with ptr=0 next cycle. Any read/write sampled in the same cycle is ignored, and DM_err pulses next cycle.
- clear_req while already in CLEAR: ignored; the clear does not restart.
- Accepted write (IDLE, DM_write=1, DM_read=0, address<DEPTH):
  - For each i with DM_be[i]=1, byte i of word[address] <= DM_in byte i at the edge.
  - Bytes with DM_be[i]=0 are unchanged; DM_be=0 leaves the word unchanged (no error).
  - DM_valid=0 next cycle.
- Accepted read (IDLE, DM_read=1, DM_write=0, address<DEPTH): DM_out<=word[address] and DM_valid=1 on the next cycle (latency 1).
- Back-to-back reads: one result per cycle.
- Write to address A then read of A on the following cycle returns the newly written bytes.
- DM_out holds its last value when DM_valid=0; DM_valid is a one-cycle pulse per accepted read.
- Rejected requests: both DM_read and DM_write high, or address>=DEPTH.
  - No array change; DM_valid=0 and DM_err=1 on the next cycle; DM_out unchanged.
- Idle cycle (no request): DM_valid=0, DM_err=0.
- Reset asserted mid-clear or mid-read: all outputs return to reset values immediately and the clear restarts from ptr=0 after release.

Test Plan:
- Reset release with DEPTH=16 -> clear_busy=1 for exactly 16 cycles, then DM_ready=1; reads of addresses 0..15 return 0x00000000 with DM_valid one cycle after each request.
- Write 0xDEADBEEF to address 5 with DM_be=4'b1111, then write 0x11223344 with DM_be=4'b0101 -> next-cycle read of 5 returns 0xDE22BE44.
- Write 0xA5A5A5A5 to address 3, read 3 on the following cycle -> DM_out=0xA5A5A5A5 with DM_valid=1 one cycle after the read.
- DM_read=DM_write=1 at address 2; then read of address 20 with DEPTH=16 -> DM_err pulses once for each; word 2 unchanged; DM_valid stays 0.
- Fill addresses 0..3 with nonzero data, pulse clear_req -> clear_busy=1 for 16 cycles, DM_ready=0 during the clear, a read request issued mid-clear is ignored with no DM_err; afterward address 3 reads 0.
- Drop rst to 0 at clear cycle 7 -> DM_valid=0 and clear_busy=1 immediately; after release the clear takes a full 16 cycles again.
